// File: rtl/apb_interconnect_tmo.sv
// APB3 1-to-N interconnect with registered slot decode, decode-error response
// for unpopulated slots, stalled-slave timeout abort and CPU-visible error status.
module apb_interconnect_tmo #(
  parameter int DW                 = 32,
  parameter int AW                 = 32,
  parameter int NUM_PERIPHERALS    = 64,
  parameter int NUM_REG_PERIPHERAL = 32,
  parameter int NUM_POPULATED      = 8,
  parameter int TIMEOUT_CYCLES     = 16,
  parameter int ERRCNT_W           = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AW-1:0]                 MpADDR,
  input  logic                          MpSELx,
  input  logic                          MpENABLE,
  input  logic                          MpWRITE,
  input  logic [DW-1:0]                 MpWDATA,
  output logic [DW-1:0]                 MpRDATA,
  output logic                          MpREADY,
  output logic                          MpSLVERR,
  output logic [AW*NUM_PERIPHERALS-1:0] SpADDR,
  output logic [NUM_PERIPHERALS-1:0]    SpSEL,
  output logic [NUM_PERIPHERALS-1:0]    SpENABLE,
  output logic [NUM_PERIPHERALS-1:0]    SpWRITE,
  output logic [DW*NUM_PERIPHERALS-1:0] SpWDATA,
  input  logic [DW*NUM_PERIPHERALS-1:0] SpRDATA,
  input  logic [NUM_PERIPHERALS-1:0]    SpREADY,
  input  logic [NUM_PERIPHERALS-1:0]    SpSLVERR,
  input  logic                          err_clr,
  output logic [ERRCNT_W-1:0]           err_cnt,
  output logic                          tmo_sticky,
  output logic                          dec_sticky
);

  localparam int IW  = $clog2(NUM_PERIPHERALS);
  localparam int LSB = $clog2(NUM_REG_PERIPHERAL) + 2;
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW:0]   NPOP    = (IW + 1)'(NUM_POPULATED);
  localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, DECERR, TMO} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt, idx_comb;
  logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
  logic            mapped, rdy, err_evt;

  assign SpADDR   = {NUM_PERIPHERALS{MpADDR}};
  assign SpWRITE  = {NUM_PERIPHERALS{MpWRITE}};
  assign SpWDATA  = {NUM_PERIPHERALS{MpWDATA}};

  assign idx_comb = MpADDR[LSB+IW-1:LSB];
  assign mapped   = {1'b0, idx_comb} < NPOP;
  assign rdy      = SpREADY[idx];

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    wait_cnt_nxt = wait_cnt;
    SpSEL        = '0;
    SpENABLE     = '0;
    MpREADY      = 1'b0;
    MpSLVERR     = 1'b0;
    MpRDATA      = '0;
    err_evt      = 1'b0;
    case (state)
      IDLE: begin
        if (MpSELx && !MpENABLE) begin
          idx_nxt      = idx_comb;
          wait_cnt_nxt = '0;
          if (mapped) begin
            SpSEL[idx_comb] = 1'b1;
            state_nxt       = ACCESS;
          end else begin
            state_nxt = DECERR;
          end
        end
      end
      ACCESS: begin
        // A master that drops PSEL mid-transfer gets no response and no status.
        if (!MpSELx) begin
          state_nxt = IDLE;
        end else begin
          SpSEL[idx]    = 1'b1;
          SpENABLE[idx] = MpENABLE;
          MpREADY       = rdy;
          MpSLVERR      = SpSLVERR[idx] & rdy;
          MpRDATA       = MpWRITE ? '0 : SpRDATA[DW*int'(idx) +: DW];
          if (rdy) begin
            state_nxt = IDLE;
            err_evt   = SpSLVERR[idx];
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
            if (wait_cnt_nxt == TMO_LIM) state_nxt = TMO;
          end
        end
      end
      DECERR, TMO: begin
        MpREADY   = 1'b1;
        MpSLVERR  = 1'b1;
        err_evt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // err_clr wins over a same-cycle event: that event is dropped.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_cnt    <= '0;
      tmo_sticky <= 1'b0;
      dec_sticky <= 1'b0;
    end else begin
      if (err_evt && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      if (state == TMO)               tmo_sticky <= 1'b1;
      if (state == DECERR)            dec_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_interconnect_tmo.sv
// Randomized transaction-level bench for apb_interconnect_tmo: a master task
// predicts every output per cycle from the transfer rules; one process compares.
module tb_apb_interconnect_tmo;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int NP   = 64;
  localparam int NR   = 32;
  localparam int NPOP = 8;
  localparam int N    = 16;
  localparam int EW   = 2;
  localparam int CMAX = (1 << EW) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    MpADDR;
  logic             MpSELx, MpENABLE, MpWRITE;
  logic [DW-1:0]    MpWDATA, MpRDATA;
  logic             MpREADY, MpSLVERR;
  logic [AW*NP-1:0] SpADDR;
  logic [NP-1:0]    SpSEL, SpENABLE, SpWRITE;
  logic [DW*NP-1:0] SpWDATA, SpRDATA;
  logic [NP-1:0]    SpREADY, SpSLVERR;
  logic             err_clr;
  logic [EW-1:0]    err_cnt;
  logic             tmo_sticky, dec_sticky;

  apb_interconnect_tmo #(
    .DW(DW), .AW(AW), .NUM_PERIPHERALS(NP), .NUM_REG_PERIPHERAL(NR),
    .NUM_POPULATED(NPOP), .TIMEOUT_CYCLES(N), .ERRCNT_W(EW)
  ) dut (
    .clk(clk), .rst(rst),
    .MpADDR(MpADDR), .MpSELx(MpSELx), .MpENABLE(MpENABLE), .MpWRITE(MpWRITE),
    .MpWDATA(MpWDATA), .MpRDATA(MpRDATA), .MpREADY(MpREADY), .MpSLVERR(MpSLVERR),
    .SpADDR(SpADDR), .SpSEL(SpSEL), .SpENABLE(SpENABLE), .SpWRITE(SpWRITE),
    .SpWDATA(SpWDATA), .SpRDATA(SpRDATA), .SpREADY(SpREADY), .SpSLVERR(SpSLVERR),
    .err_clr(err_clr), .err_cnt(err_cnt), .tmo_sticky(tmo_sticky), .dec_sticky(dec_sticky)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: expected combinational outputs of the current cycle plus status.
  bit            exp_on = 0;
  logic [NP-1:0] exp_sel, exp_en;
  logic          exp_ready, exp_slverr;
  logic [DW-1:0] exp_rdata;
  int            m_cnt = 0;
  bit            m_tmo = 0, m_dec = 0;
  bit            ev_err = 0, ev_tmo = 0, ev_dec = 0;
  bit            rnd_clr = 0;
  int            cur_k = 0;

  logic [DW-1:0] last_rdata;
  logic          last_slverr;
  logic [NP-1:0] last_sel;
  int            last_k;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    int j;
    if (exp_on) begin
      check("spsel",      SpSEL,      exp_sel);
      check("spenable",   SpENABLE,   exp_en);
      check("mpready",    MpREADY,    exp_ready);
      check("mpslverr",   MpSLVERR,   exp_slverr);
      check("mprdata",    MpRDATA,    exp_rdata);
      check("err_cnt",    err_cnt,    64'(m_cnt));
      check("tmo_sticky", tmo_sticky, m_tmo);
      check("dec_sticky", dec_sticky, m_dec);
      j = $urandom_range(0, NP - 1);
      check("spaddr",  SpADDR[j*AW +: AW],  MpADDR);
      check("spwdata", SpWDATA[j*DW +: DW], MpWDATA);
      check("spwrite", SpWRITE, {NP{MpWRITE}});
      if (MpREADY) begin
        last_rdata  = MpRDATA;
        last_slverr = MpSLVERR;
        last_sel    = SpSEL;
        last_k      = cur_k;
      end
    end
  end

  // Close the cycle: status registers take this cycle's events at the edge.
  task automatic advance();
    @(posedge clk);
    if (rst || err_clr) begin
      m_cnt = 0; m_tmo = 0; m_dec = 0;
    end else begin
      if (ev_err && m_cnt < CMAX) m_cnt++;
      if (ev_tmo) m_tmo = 1;
      if (ev_dec) m_dec = 1;
    end
    ev_err = 0; ev_tmo = 0; ev_dec = 0;
    #1;
  endtask

  function automatic logic rclr();
    return rnd_clr && ($urandom_range(0, 15) == 0);
  endfunction

  task automatic rand_slaves();
    for (int i = 0; i < NP; i++) SpRDATA[i*DW +: DW] = $urandom;
    SpREADY  = {$urandom, $urandom};
    SpSLVERR = {$urandom, $urandom};
  endtask

  task automatic set_idle_exp();
    exp_sel = '0; exp_en = '0; exp_ready = 0; exp_slverr = 0; exp_rdata = '0;
  endtask

  task automatic idle_cycle();
    MpSELx = 0; MpENABLE = 0; MpADDR = $urandom; MpWRITE = 1'($urandom);
    MpWDATA = $urandom; err_clr = rclr();
    rand_slaves();
    set_idle_exp();
    cur_k = 0;
    advance();
  endtask

  // One APB transfer. The target slave is ready after w wait cycles; a
  // mapped transfer times out once N ACCESS cycles have passed without ready.
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input int w,
                      input logic serr, input logic [DW-1:0] rd,
                      input bit chg, input logic [AW-1:0] chg_addr,
                      input int rst_at, input bit clr_resp);
    int s;
    bit mapped, done;
    s = int'(addr[12:7]);
    mapped = s < NPOP;
    MpSELx = 1; MpENABLE = 0; MpADDR = addr; MpWRITE = wr; MpWDATA = $urandom;
    err_clr = rclr();
    rand_slaves();
    cur_k = 0;
    set_idle_exp();
    if (mapped) exp_sel = NP'(1) << s;
    advance();
    done = 0;
    for (int k = 1; !done; k++) begin
      cur_k = k;
      MpENABLE = 1;
      if (chg) MpADDR = chg_addr;
      err_clr = rclr();
      rand_slaves();
      SpREADY[s] = (k > w);
      SpSLVERR[s] = serr;
      SpRDATA[s*DW +: DW] = rd;
      if (k == rst_at) begin
        rst = 1;
        SpREADY[s] = 0;
      end
      set_idle_exp();
      if (!mapped) begin
        exp_ready = 1; exp_slverr = 1;
        ev_err = 1; ev_dec = 1; done = 1;
      end else if (k == N + 1) begin
        exp_ready = 1; exp_slverr = 1;
        ev_err = 1; ev_tmo = 1; done = 1;
      end else begin
        exp_sel    = NP'(1) << s;
        exp_en     = NP'(1) << s;
        exp_ready  = SpREADY[s];
        exp_slverr = SpREADY[s] & serr;
        exp_rdata  = wr ? '0 : rd;
        if (SpREADY[s]) begin
          ev_err = serr;
          done = 1;
        end
      end
      if (clr_resp && done) err_clr = 1;
      if (k == rst_at) done = 1;
      advance();
      if (k == rst_at) rst = 0;
    end
    MpSELx = 0; MpENABLE = 0; err_clr = 0;
  endtask

  function automatic logic [AW-1:0] slot_addr(input int s);
    logic [AW-1:0] a;
    a = $urandom;
    a[12:7] = 6'(s);
    a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; MpADDR = '0; MpSELx = 0; MpENABLE = 0; MpWRITE = 0; MpWDATA = '0;
    SpRDATA = '0; SpREADY = '0; SpSLVERR = '0; err_clr = 0;
    set_idle_exp();
    advance();
    advance();
    rst = 0;
    exp_on = 1;
    check("rst_err_cnt", err_cnt, 0);
    check("rst_tmo", tmo_sticky, 0);
    check("rst_dec", dec_sticky, 0);
    idle_cycle();
    idle_cycle();

    // Mapped read, slot 3, two wait cycles.
    xfer(32'h180, 0, 2, 0, 32'hDEADBEEF, 0, '0, 0, 0);
    check("t1_rdata", last_rdata, 32'hDEADBEEF);
    check("t1_latency", last_k, 3);
    check("t1_slverr", last_slverr, 0);
    check("t1_sel", last_sel, 64'h8);
    idle_cycle();

    // Unmapped write, slot 16.
    xfer(32'h800, 1, 0, 0, '0, 0, '0, 0, 0);
    check("t2_latency", last_k, 1);
    check("t2_slverr", last_slverr, 1);
    check("t2_dec", dec_sticky, 1);
    check("t2_cnt", err_cnt, 1);

    // Timeout on slot 2.
    xfer(32'h100, 0, 1000, 0, 32'h5555AAAA, 0, '0, 0, 0);
    check("t3_latency", last_k, N + 1);
    check("t3_slverr", last_slverr, 1);
    check("t3_sel", last_sel, 0);
    check("t3_tmo", tmo_sticky, 1);
    check("t3_cnt", err_cnt, 2);

    // Address moves to slot 5 during ACCESS; slot 1 still answers.
    xfer(32'h080, 0, 1, 0, 32'h12345678, 1, 32'h280, 0, 0);
    check("t4_sel", last_sel, 64'h2);
    check("t4_rdata", last_rdata, 32'h12345678);
    check("t4_latency", last_k, 2);

    // Saturation, then clear racing a sixth error.
    for (int i = 0; i < 5; i++) xfer(32'h800, 0, 0, 0, '0, 0, '0, 0, 0);
    check("t5_sat", err_cnt, 3);
    xfer(32'h800, 0, 0, 0, '0, 0, '0, 0, 1);
    check("t5_clr_cnt", err_cnt, 0);
    check("t5_clr_tmo", tmo_sticky, 0);
    check("t5_clr_dec", dec_sticky, 0);

    // Reset in the third ACCESS cycle of slot 4, then a fresh transfer.
    xfer(32'h200, 0, 10, 0, 32'hCAFEF00D, 0, '0, 3, 0);
    #1;
    check("t6_sel", SpSEL, 0);
    check("t6_ready", MpREADY, 0);
    idle_cycle();
    xfer(32'h200, 1, 0, 1, 32'h0, 0, '0, 0, 0);
    check("t6_fresh_latency", last_k, 1);
    check("t6_fresh_slverr", last_slverr, 1);
    check("t6_fresh_rdata", last_rdata, 0);

    // Random traffic, including back-to-back transfers and random err_clr.
    rnd_clr = 1;
    for (int t = 0; t < 300; t++) begin
      int s, w, sel;
      s = ($urandom_range(0, 3) != 0) ? $urandom_range(0, NPOP - 1)
                                      : $urandom_range(NPOP, NP - 1);
      sel = $urandom_range(0, 9);
      case (sel)
        6:       w = N - 1;
        7:       w = N;
        8:       w = N + 3;
        default: w = sel % 4;
      endcase
      xfer(slot_addr(s), 1'($urandom), w, 1'($urandom_range(0, 3) == 0), $urandom,
           $urandom_range(0, 3) == 0, slot_addr($urandom_range(0, NP - 1)), 0, 0);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    rnd_clr = 0;
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
